// File: rtl/grant_responder_pkg.sv
// Shared arbiter definitions: responder state encoding, master count and
// default burst-length width, plus the index-to-grant helper.
package grant_responder_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int DEFAULT_LW  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ACKS = 2'd2,
        ST_WREL = 2'd3
    } state_t;

    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [1:0] idx);
        return {{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/grant_responder_onehot_check.sv
// Classifies a grant vector: valid when exactly one bit is set, with its index.
module onehot_check
    import grant_responder_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] grant_i,
    output logic                   valid_o,
    output logic [1:0]             idx_o
);

    // x & (x-1) clears the lowest set bit, so zero result means at most one bit
    always_comb begin
        valid_o = (grant_i != 4'b0000) && ((grant_i & (grant_i - 4'd1)) == 4'b0000);
        case (grant_i)
            4'b0010: idx_o = 2'd1;
            4'b0100: idx_o = 2'd2;
            4'b1000: idx_o = 2'd3;
            default: idx_o = 2'd0;
        endcase
    end

endmodule

// File: rtl/grant_responder.sv
// Serves one granted master per burst: beats, a single ACK, then waits for the
// arbiter to release the grant before accepting a new one.
module grant_responder
    import grant_responder_pkg::*;
#(
    parameter int LW = DEFAULT_LW
)(
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_MASTERS-1:0]    GRANT,
    input  logic [NUM_MASTERS*LW-1:0] LEN,
    output logic                      ACK,
    output logic                      BUSY,
    output logic [1:0]                OWNER,
    output logic                      BEAT,
    output logic [LW-1:0]             BEAT_CNT,
    output logic                      ERR,
    output logic [7:0]                DONE_CNT
);

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [7:0]      done_q, done_d;

    logic            grant_valid_s;
    logic [1:0]      grant_idx_s;
    logic [LW-1:0]   len_sel_s;
    logic            grant_kept_s;

    onehot_check u_onehot_check (
        .grant_i (GRANT),
        .valid_o (grant_valid_s),
        .idx_o   (grant_idx_s)
    );

    assign len_sel_s    = LEN[grant_idx_s*LW +: LW];
    assign grant_kept_s = (GRANT == idx_to_onehot(owner_q));

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_d = ST_XFER;
                    owner_d = grant_idx_s;
                    cnt_d   = (len_sel_s == '0) ? LW'(1) : len_sel_s;
                end else if (GRANT != 4'b0000) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!grant_kept_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == LW'(1)) begin
                    state_d = ST_ACKS;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - LW'(1);
                end
            end
            ST_ACKS: begin
                state_d = ST_WREL;
                if (done_q != 8'hFF) begin
                    done_d = done_q + 8'd1;
                end else begin
                    done_d = done_q;
                end
            end
            ST_WREL: begin
                if (!grant_kept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WREL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from state or taken straight from registers
    always_comb begin
        BUSY = (state_q != ST_IDLE);
        BEAT = (state_q == ST_XFER);
        ACK  = (state_q == ST_ACKS);
    end

    assign OWNER    = owner_q;
    assign BEAT_CNT = cnt_q;
    assign ERR      = err_q;
    assign DONE_CNT = done_q;

endmodule
